violation_reset_ctrl: RTL and testbench

Collects reset requests from the hardware security monitors (atomicity monitor `reset`, memory-access monitor, DMA monitor) and turns them into a single, stretched, registered PUC request for the openMSP430 core. It records the cause, the violating PC and a saturating violation count, so trusted software can read them after reboot. A blanking window lets upstream monitors observe the reset-handler fetch and release their requests before new requests are honoured.

---
 rtl/violation_reset_ctrl.sv | 134 +++++++++++++
 tb/tb_violation_reset_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/violation_reset_ctrl.sv
// Merges security-monitor reset requests into one stretched, registered PUC request and
// logs the cause, PC and a saturating count of each trigger for post-reboot inspection.
module violation_reset_ctrl #(
  parameter int unsigned HOLD_CYCLES  = 8,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             atom_rst,
  input  logic             mem_rst,
  input  logic             dma_rst,
  input  logic [15:0]      pc,
  input  logic             cause_clr,
  output logic             puc_req,
  output logic [2:0]       cause,
  output logic [15:0]      viol_pc,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             busy
);

  localparam int unsigned MaxCycles = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  // A single-cycle window still needs a one-bit counter to keep the vector legal.
  localparam int unsigned CntWidth  = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntWidth-1:0] HoldLast  = CntWidth'(HOLD_CYCLES - 1);
  localparam logic [CntWidth-1:0] BlankLast = CntWidth'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StBlank
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                req_any;
  logic                trigger;

  logic                puc_req_q, puc_req_d;
  logic                busy_q, busy_d;
  logic [2:0]          cause_q, cause_d;
  logic [15:0]         viol_pc_q, viol_pc_d;
  logic [CNT_W-1:0]    viol_cnt_q, viol_cnt_d;
  logic [CNT_W-1:0]    cnt_base;

  assign req_any = atom_rst | mem_rst | dma_rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trigger = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          state_d = StHold;
          cnt_d   = '0;
          trigger = 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StBlank;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StBlank: begin
        // Released requests take priority over the blanking timeout.
        if (!req_any) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == BlankLast) begin
          state_d = StHold;
          cnt_d   = '0;
          trigger = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // A trigger coinciding with cause_clr wins; the count then restarts from zero.
  always_comb begin
    cnt_base   = cause_clr ? '0 : viol_cnt_q;
    cause_d    = cause_clr ? 3'b000 : cause_q;
    viol_pc_d  = cause_clr ? 16'h0000 : viol_pc_q;
    viol_cnt_d = cnt_base;
    if (trigger) begin
      cause_d    = {dma_rst, mem_rst, atom_rst};
      viol_pc_d  = pc;
      viol_cnt_d = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they are flops, not state decodes.
  always_comb begin
    puc_req_d = (state_d == StHold);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      puc_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      cause_q    <= 3'b000;
      viol_pc_q  <= 16'h0000;
      viol_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      puc_req_q  <= puc_req_d;
      busy_q     <= busy_d;
      cause_q    <= cause_d;
      viol_pc_q  <= viol_pc_d;
      viol_cnt_q <= viol_cnt_d;
    end
  end

  assign puc_req  = puc_req_q;
  assign busy     = busy_q;
  assign cause    = cause_q;
  assign viol_pc  = viol_pc_q;
  assign viol_cnt = viol_cnt_q;

endmodule

// File: tb/tb_violation_reset_ctrl.sv
// Directed bench for violation_reset_ctrl; a second instance with a 2-bit counter shares
// the stimulus to exercise count saturation.
module tb_violation_reset_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        atom_rst, mem_rst, dma_rst;
  logic [15:0] pc;
  logic        cause_clr;

  logic        puc_req, busy;
  logic [2:0]  cause;
  logic [15:0] viol_pc;
  logic [7:0]  viol_cnt;

  logic        puc_req2, busy2;
  logic [2:0]  cause2;
  logic [15:0] viol_pc2;
  logic [1:0]  viol_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  violation_reset_ctrl #(.HOLD_CYCLES(8), .BLANK_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .atom_rst(atom_rst), .mem_rst(mem_rst),
    .dma_rst(dma_rst), .pc(pc), .cause_clr(cause_clr), .puc_req(puc_req),
    .cause(cause), .viol_pc(viol_pc), .viol_cnt(viol_cnt), .busy(busy)
  );

  violation_reset_ctrl #(.HOLD_CYCLES(8), .BLANK_CYCLES(16), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .atom_rst(atom_rst), .mem_rst(mem_rst),
    .dma_rst(dma_rst), .pc(pc), .cause_clr(cause_clr), .puc_req(puc_req2),
    .cause(cause2), .viol_pc(viol_pc2), .viol_cnt(viol_cnt2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; atom_rst = 1'b0; mem_rst = 1'b0; dma_rst = 1'b0;
    pc = 16'h0000; cause_clr = 1'b0;
    #3;
    checks++;
    if ({puc_req, busy, cause, viol_pc, viol_cnt} !== 29'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {puc_req, busy, cause, viol_pc, viol_cnt});
    end
    checks++;
    if ({puc_req2, busy2, cause2, viol_pc2, viol_cnt2} !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs_sat: got %h expected 0",
               {puc_req2, busy2, cause2, viol_pc2, viol_cnt2});
    end
    tick(); tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if ({puc_req, busy, viol_cnt} !== 10'h0) begin
      errors++;
      $display("FAIL reset_release_idle: got %h expected 0", {puc_req, busy, viol_cnt});
    end
  endtask

  // Expects all logs to start at zero (fresh out of reset).
  task automatic test_single();
    atom_rst = 1'b1; pc = 16'hE010;
    tick();
    atom_rst = 1'b0; pc = 16'h0000;
    checks++;
    if ({puc_req, busy, cause, viol_pc, viol_cnt} !== {1'b1, 1'b1, 3'b001, 16'hE010, 8'd1}) begin
      errors++;
      $display("FAIL single_trigger: got puc=%b busy=%b cause=%b pc=%h cnt=%0d expected 1 1 001 e010 1",
               puc_req, busy, cause, viol_pc, viol_cnt);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (puc_req !== 1'b1) begin
        errors++;
        $display("FAIL single_hold cycle %0d: got puc=%b expected 1", i, puc_req);
      end
    end
    tick();
    checks++;
    if ({puc_req, busy} !== 2'b01) begin
      errors++;
      $display("FAIL single_hold_end: got puc=%b busy=%b expected 0 1", puc_req, busy);
    end
    tick();
    checks++;
    if ({puc_req, busy, viol_cnt} !== {1'b0, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL single_idle: got puc=%b busy=%b cnt=%0d expected 0 0 1",
               puc_req, busy, viol_cnt);
    end
  endtask

  task automatic test_simultaneous();
    atom_rst = 1'b1; mem_rst = 1'b1; pc = 16'h1234;
    tick();
    atom_rst = 1'b0; mem_rst = 1'b0;
    checks++;
    if ({puc_req, cause, viol_pc, viol_cnt} !== {1'b1, 3'b011, 16'h1234, 8'd2}) begin
      errors++;
      $display("FAIL simultaneous: got puc=%b cause=%b pc=%h cnt=%0d expected 1 011 1234 2",
               puc_req, cause, viol_pc, viol_cnt);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if ({busy, viol_cnt, viol_cnt2} !== {1'b0, 8'd2, 2'd2}) begin
      errors++;
      $display("FAIL simultaneous_idle: got busy=%b cnt=%0d cnt_sat=%0d expected 0 2 2",
               busy, viol_cnt, viol_cnt2);
    end
  endtask

  task automatic test_blanking();
    atom_rst = 1'b1; pc = 16'h2000;
    tick();
    checks++;
    if ({puc_req, cause, viol_cnt} !== {1'b1, 3'b001, 8'd3}) begin
      errors++;
      $display("FAIL blank_trigger: got puc=%b cause=%b cnt=%0d expected 1 001 3",
               puc_req, cause, viol_cnt);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (puc_req !== 1'b1) begin
        errors++;
        $display("FAIL blank_hold cycle %0d: got puc=%b expected 1", i, puc_req);
      end
    end
    for (int j = 0; j < 6; j++) begin
      tick();
      checks++;
      if ({puc_req, busy} !== 2'b01) begin
        errors++;
        $display("FAIL blank_window cycle %0d: got puc=%b busy=%b expected 0 1", j, puc_req, busy);
      end
    end
    atom_rst = 1'b0;
    tick();
    checks++;
    if ({puc_req, busy, viol_cnt, viol_cnt2} !== {1'b0, 1'b0, 8'd3, 2'd3}) begin
      errors++;
      $display("FAIL blank_release: got puc=%b busy=%b cnt=%0d cnt_sat=%0d expected 0 0 3 3",
               puc_req, busy, viol_cnt, viol_cnt2);
    end
  endtask

  task automatic test_clear_alone();
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    checks++;
    if ({busy, cause, viol_pc, viol_cnt, viol_cnt2} !== 30'h0) begin
      errors++;
      $display("FAIL clear_alone: got busy=%b cause=%b pc=%h cnt=%0d cnt_sat=%0d expected all 0",
               busy, cause, viol_pc, viol_cnt, viol_cnt2);
    end
  endtask

  task automatic test_persistent();
    logic       exp_puc;
    logic [7:0] exp_cnt;
    logic [1:0] exp_cnt2;
    int         waited;
    dma_rst = 1'b1; pc = 16'hC0DE;
    for (int k = 0; k < 100; k++) begin
      tick();
      exp_puc  = ((k % 24) < 8);
      exp_cnt  = 8'(k / 24 + 1);
      exp_cnt2 = (exp_cnt > 8'd3) ? 2'd3 : exp_cnt[1:0];
      checks++;
      if ({puc_req, busy, cause, viol_cnt, viol_cnt2} !== {exp_puc, 1'b1, 3'b100, exp_cnt, exp_cnt2})
      begin
        errors++;
        $display("FAIL persistent cycle %0d: got puc=%b busy=%b cause=%b cnt=%0d cnt_sat=%0d expected %b 1 100 %0d %0d",
                 k, puc_req, busy, cause, viol_cnt, viol_cnt2, exp_puc, exp_cnt, exp_cnt2);
      end
    end
    dma_rst = 1'b0;
    waited = 0;
    while (busy !== 1'b0 && waited < 40) begin
      tick();
      waited++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL persistent_drain: got busy=%b after %0d cycles expected 0", busy, waited);
    end
  endtask

  task automatic test_clear_coincident();
    mem_rst = 1'b1; pc = 16'h4400; cause_clr = 1'b1;
    tick();
    mem_rst = 1'b0; cause_clr = 1'b0;
    checks++;
    if ({puc_req, cause, viol_pc, viol_cnt, viol_cnt2} !== {1'b1, 3'b010, 16'h4400, 8'd1, 2'd1}) begin
      errors++;
      $display("FAIL clear_coincident: got puc=%b cause=%b pc=%h cnt=%0d cnt_sat=%0d expected 1 010 4400 1 1",
               puc_req, cause, viol_pc, viol_cnt, viol_cnt2);
    end
    tick(); tick();
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    checks++;
    if ({puc_req, busy, cause, viol_pc, viol_cnt} !== {1'b1, 1'b1, 27'h0}) begin
      errors++;
      $display("FAIL clear_in_hold: got puc=%b busy=%b cause=%b pc=%h cnt=%0d expected 1 1 0 0 0",
               puc_req, busy, cause, viol_pc, viol_cnt);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_return_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_async_reset();
    atom_rst = 1'b1; pc = 16'hBEEF;
    tick();
    atom_rst = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (puc_req !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_hold: got puc=%b expected 1", puc_req);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({puc_req, busy, cause, viol_pc, viol_cnt} !== 29'h0) begin
      errors++;
      $display("FAIL async_reset: got puc=%b busy=%b cause=%b pc=%h cnt=%0d expected all 0",
               puc_req, busy, cause, viol_pc, viol_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_blanking();
    test_clear_alone();
    test_persistent();
    test_clear_coincident();
    test_async_reset();
    test_single();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
